// File: rtl/bk_pkg.sv
// Shared types and defaults for the save-state sector sequencer.
package bk_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        XFER,
        FIN,
        ERR
    } bk_state_t;

    localparam int unsigned BK_DEFAULT_SECTORS = 64;
    localparam logic [23:0] BK_DEFAULT_TIMEOUT = 24'd5_000_000;

endpackage

// File: rtl/bk_sequencer_if.sv
// SD sector request/acknowledge handshake between the sequencer and hps_io.
interface bk_sequencer_if;

    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;

    modport master (
        output sd_lba,
        output sd_rd,
        output sd_wr,
        input  sd_ack
    );

    modport slave (
        input  sd_lba,
        input  sd_rd,
        input  sd_wr,
        output sd_ack
    );

endinterface

// File: rtl/bk_edge.sv
// Registered rising/falling edge detector; pulses appear one cycle after the input changes.
module bk_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q  <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            d_q  <= d;
            rise <= d & ~d_q;
            fall <= ~d & d_q;
        end
    end

endmodule

// File: rtl/bk_sequencer.sv
// Turns OSD load/save commands into a burst of SD sector transfers for one save slot,
// with timeout and download-abort reporting.
module bk_sequencer
    import bk_pkg::*;
#(
    parameter int unsigned SECTORS   = BK_DEFAULT_SECTORS,
    parameter int unsigned SLOT_BITS = 2,
    parameter logic [23:0] TIMEOUT   = BK_DEFAULT_TIMEOUT
) (
    input  logic                 clk_sys,
    input  logic                 RESET_n,
    input  logic                 downloading,
    input  logic                 img_mounted,
    input  logic                 img_readonly,
    input  logic                 img_size_nz,
    input  logic                 load_req,
    input  logic                 save_req,
    input  logic [SLOT_BITS-1:0] slot,
    bk_sequencer_if.master       sd,
    output logic                 bk_ena,
    output logic                 bk_loading,
    output logic                 bk_busy,
    output logic                 bk_done,
    output logic                 bk_err
);

    localparam int unsigned LB = $clog2(SECTORS);

    logic load_rise, save_rise, dl_rise, ack_rise, ack_fall;
    logic load_fall_unused, save_fall_unused, dl_fall_unused;

    bk_state_t            state_q, state_d;
    logic                 dir_q, dir_d;
    logic [SLOT_BITS-1:0] slot_q, slot_d;
    logic [LB-1:0]        sec_q, sec_d;
    logic                 rd_q, rd_d;
    logic                 wr_q, wr_d;
    logic                 loading_q, loading_d;
    logic                 busy_q, busy_d;
    logic                 abort_q, abort_d;
    logic [23:0]          cnt_q, cnt_d;
    logic                 ena_q;
    logic                 ena_set;

    bk_edge u_load_edge (
        .clk  (clk_sys),
        .rst_n(RESET_n),
        .d    (load_req & ena_q),
        .rise (load_rise),
        .fall (load_fall_unused)
    );

    bk_edge u_save_edge (
        .clk  (clk_sys),
        .rst_n(RESET_n),
        .d    (save_req & ena_q),
        .rise (save_rise),
        .fall (save_fall_unused)
    );

    bk_edge u_dl_edge (
        .clk  (clk_sys),
        .rst_n(RESET_n),
        .d    (downloading),
        .rise (dl_rise),
        .fall (dl_fall_unused)
    );

    bk_edge u_ack_edge (
        .clk  (clk_sys),
        .rst_n(RESET_n),
        .d    (sd.sd_ack),
        .rise (ack_rise),
        .fall (ack_fall)
    );

    // A fresh writable mount wins over the download-start clear in the same cycle.
    assign ena_set = downloading & img_mounted & img_size_nz & ~img_readonly;

    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            ena_q <= 1'b0;
        end else if (ena_set) begin
            ena_q <= 1'b1;
        end else if (dl_rise) begin
            ena_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q   <= IDLE;
            dir_q     <= 1'b0;
            slot_q    <= '0;
            sec_q     <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            loading_q <= 1'b0;
            busy_q    <= 1'b0;
            abort_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            slot_q    <= slot_d;
            sec_q     <= sec_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            loading_q <= loading_d;
            busy_q    <= busy_d;
            abort_q   <= abort_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        slot_d    = slot_q;
        sec_d     = sec_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        loading_d = loading_q;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        abort_d   = abort_q | (dl_rise & (state_q != IDLE));

        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (load_rise | save_rise) begin
                    dir_d     = load_rise;
                    slot_d    = slot;
                    sec_d     = '0;
                    rd_d      = load_rise;
                    wr_d      = ~load_rise;
                    loading_d = load_rise;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (ack_rise) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = XFER;
                end else if (cnt_q == TIMEOUT - 24'd1) begin
                    rd_d      = 1'b0;
                    wr_d      = 1'b0;
                    loading_d = 1'b0;
                    busy_d    = 1'b0;
                    state_d   = ERR;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            XFER: begin
                if (ack_fall) begin
                    if ((&sec_q) || abort_d) begin
                        state_d = FIN;
                    end else begin
                        sec_d   = sec_q + LB'(1);
                        rd_d    = dir_q;
                        wr_d    = ~dir_q;
                        cnt_d   = '0;
                        state_d = REQ;
                    end
                end
            end
            FIN: begin
                loading_d = 1'b0;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            ERR: begin
                rd_d      = 1'b0;
                wr_d      = 1'b0;
                loading_d = 1'b0;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign sd.sd_lba  = 32'({slot_q, sec_q});
    assign sd.sd_rd   = rd_q;
    assign sd.sd_wr   = wr_q;
    assign bk_ena     = ena_q;
    assign bk_loading = loading_q;
    assign bk_busy    = busy_q;
    assign bk_done    = (state_q == FIN) & ~abort_q;
    assign bk_err     = ((state_q == FIN) & abort_q) | (state_q == ERR);

endmodule

// File: tb/tb_bk_sequencer.sv
// Directed bench for bk_sequencer with a simple hps_io acknowledge model.
module tb_bk_sequencer;

    logic       clk_sys = 1'b0;
    logic       RESET_n = 1'b0;
    logic       downloading = 1'b0;
    logic       img_mounted = 1'b0;
    logic       img_readonly = 1'b0;
    logic       img_size_nz = 1'b0;
    logic       load_req = 1'b0;
    logic       save_req = 1'b0;
    logic [1:0] slot = 2'd0;
    logic       bk_ena, bk_loading, bk_busy, bk_done, bk_err;
    bit         ack_en = 1'b1;

    bk_sequencer_if sd ();

    bk_sequencer #(
        .SECTORS  (64),
        .SLOT_BITS(2),
        .TIMEOUT  (24'd100)
    ) dut (
        .clk_sys     (clk_sys),
        .RESET_n     (RESET_n),
        .downloading (downloading),
        .img_mounted (img_mounted),
        .img_readonly(img_readonly),
        .img_size_nz (img_size_nz),
        .load_req    (load_req),
        .save_req    (save_req),
        .slot        (slot),
        .sd          (sd),
        .bk_ena      (bk_ena),
        .bk_loading  (bk_loading),
        .bk_busy     (bk_busy),
        .bk_done     (bk_done),
        .bk_err      (bk_err)
    );

    always #5 clk_sys = ~clk_sys;

    // hps_io model: ack rises 5 cycles after a request is seen and stays high 10 cycles.
    initial begin
        sd.sd_ack = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            if (ack_en && (sd.sd_rd || sd.sd_wr)) begin
                repeat (5) @(posedge clk_sys);
                #1 sd.sd_ack = 1'b1;
                repeat (10) @(posedge clk_sys);
                #1 sd.sd_ack = 1'b0;
            end
        end
    end

    int          cyc = 0;
    int          n_log = 0;
    logic [31:0] lba_log [0:1023];
    logic        rd_log  [0:1023];
    int          done_cnt = 0, err_cnt = 0, load_cyc = 0, viol = 0, ack_falls = 0;
    int          rise_cyc = 0, fall_cyc = 0;
    int          rise_to_drop = 0, fall_to_req = 0, fall_to_done = 0;
    logic        done_loading = 1'b0;
    logic        ack_p = 1'b0, rd_p = 1'b0, wr_p = 1'b0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        ack_p <= sd.sd_ack;
        rd_p  <= sd.sd_rd;
        wr_p  <= sd.sd_wr;
        if ((sd.sd_rd | sd.sd_wr) & ~(rd_p | wr_p)) begin
            if (n_log < 1024) begin
                lba_log[n_log] <= sd.sd_lba;
                rd_log[n_log]  <= sd.sd_rd;
            end
            n_log       <= n_log + 1;
            fall_to_req <= cyc - fall_cyc;
        end
        if ((rd_p | wr_p) & ~(sd.sd_rd | sd.sd_wr)) rise_to_drop <= cyc - rise_cyc;
        if (sd.sd_ack & ~ack_p) rise_cyc <= cyc;
        if (~sd.sd_ack & ack_p) begin
            fall_cyc  <= cyc;
            ack_falls <= ack_falls + 1;
        end
        if (bk_done) begin
            done_cnt     <= done_cnt + 1;
            fall_to_done <= cyc - fall_cyc;
            done_loading <= bk_loading;
        end
        if (bk_err) err_cnt <= err_cnt + 1;
        if (bk_loading) load_cyc <= load_cyc + 1;
        if ((sd.sd_rd & sd.sd_wr) | (sd.sd_rd & ~bk_loading) | (sd.sd_wr & bk_loading) |
            (bk_loading & ~bk_busy) | (bk_done & bk_err))
            viol <= viol + 1;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (!bk_busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic mount(input logic ro);
        downloading = 1'b1;
        repeat (3) tick();
        img_readonly = ro;
        img_size_nz  = 1'b1;
        img_mounted  = 1'b1;
        tick();
        img_mounted = 1'b0;
        tick();
        downloading = 1'b0;
        repeat (2) tick();
    endtask

    task automatic check_seq(input string tag, input int first, input int num,
                             input logic [31:0] base, input logic rd_exp);
        int bad = 0;
        for (int i = 0; i < num; i++) begin
            if (lba_log[first+i] !== base + 32'(i) || rd_log[first+i] !== rd_exp) bad++;
        end
        check(tag, 32'(bad), 32'd0);
    endtask

    int n0, d0, e0, lc0, v0, f0;
    bit ok;

    task automatic snap();
        n0  = n_log;
        d0  = done_cnt;
        e0  = err_cnt;
        lc0 = load_cyc;
        v0  = viol;
        f0  = ack_falls;
    endtask

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        check("rst_flags", 32'({sd.sd_rd, sd.sd_wr, bk_ena, bk_loading, bk_busy, bk_done, bk_err}),
              32'd0);
        check("rst_lba", sd.sd_lba, 32'd0);
        RESET_n = 1'b1;
        repeat (2) tick();

        mount(1'b0);
        check("ena_writable", 32'(bk_ena), 32'd1);
        mount(1'b1);
        check("ena_readonly", 32'(bk_ena), 32'd0);

        snap();
        load_req = 1'b1;
        repeat (30) tick();
        check("noena_reqs", 32'(n_log - n0), 32'd0);
        check("noena_busy", 32'(bk_busy), 32'd0);
        load_req = 1'b0;
        tick();

        // Save, slot 2; slot changes mid-transfer must not matter.
        mount(1'b0);
        snap();
        slot     = 2'd2;
        save_req = 1'b1;
        tick();
        check("save_lat_n1", 32'(sd.sd_wr), 32'd0);
        tick();
        check("save_lat_n2", 32'(sd.sd_wr), 32'd1);
        check("save_lba0", sd.sd_lba, 32'h80);
        save_req = 1'b0;
        slot     = 2'd3;
        wait_idle(3000, ok);
        check("save_finished", 32'(ok), 32'd1);
        check("save_count", 32'(n_log - n0), 32'd64);
        check_seq("save_seq", n0, 64, 32'h80, 1'b0);
        check("save_last_lba", lba_log[n0+63], 32'hBF);
        check("save_done", 32'(done_cnt - d0), 32'd1);
        check("save_err", 32'(err_cnt - e0), 32'd0);
        check("save_loading", 32'(load_cyc - lc0), 32'd0);
        check("save_viol", 32'(viol - v0), 32'd0);
        check("ack_rise_to_drop", 32'(rise_to_drop), 32'd2);
        check("ack_fall_to_req", 32'(fall_to_req), 32'd2);
        check("ack_fall_to_done", 32'(fall_to_done), 32'd2);
        repeat (3) tick();

        // Load, slot 0.
        snap();
        slot     = 2'd0;
        load_req = 1'b1;
        repeat (2) tick();
        check("load_lat_rd", 32'({sd.sd_rd, bk_loading}), 32'd3);
        load_req = 1'b0;
        wait_idle(3000, ok);
        check("load_finished", 32'(ok), 32'd1);
        check("load_count", 32'(n_log - n0), 32'd64);
        check_seq("load_seq", n0, 64, 32'h00, 1'b1);
        check("load_done", 32'(done_cnt - d0), 32'd1);
        check("load_loading_at_done", 32'(done_loading), 32'd1);
        check("load_loading_after", 32'(bk_loading), 32'd0);
        check("load_viol", 32'(viol - v0), 32'd0);
        repeat (3) tick();

        // Timeout: no acks at all.
        ack_en = 1'b0;
        snap();
        slot     = 2'd1;
        save_req = 1'b1;
        repeat (2) tick();
        check("to_req", 32'(sd.sd_wr), 32'd1);
        save_req = 1'b0;
        repeat (99) tick();
        check("to_not_yet", 32'({bk_err, sd.sd_wr, bk_busy}), 32'b011);
        tick();
        check("to_err", 32'({bk_err, sd.sd_wr, sd.sd_rd, bk_busy, bk_loading, bk_done}),
              32'b100000);
        tick();
        check("to_err_pulse", 32'(bk_err), 32'd0);
        check("to_err_count", 32'(err_cnt - e0), 32'd1);
        ack_en = 1'b1;
        repeat (3) tick();
        snap();
        save_req = 1'b1;
        repeat (2) tick();
        save_req = 1'b0;
        wait_idle(3000, ok);
        check("to_resave", 32'({ok, 1'(done_cnt - d0)}), 32'b11);
        check("to_resave_first", lba_log[n0], 32'h40);
        repeat (3) tick();

        // Abort: download starts during sector 0x05.
        snap();
        slot     = 2'd3;
        load_req = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (n_log - n0 >= 6 && sd.sd_ack) begin
                ok = 1'b1;
                break;
            end
        end
        check("abort_reach_sec5", 32'(ok), 32'd1);
        load_req    = 1'b0;
        downloading = 1'b1;
        wait_idle(500, ok);
        check("abort_finished", 32'(ok), 32'd1);
        check("abort_count", 32'(n_log - n0), 32'd6);
        check("abort_last_lba", lba_log[n0+5], 32'hC5);
        check("abort_sec_done", 32'(ack_falls - f0), 32'd6);
        check("abort_err", 32'(err_cnt - e0), 32'd1);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_ena", 32'(bk_ena), 32'd0);
        downloading = 1'b0;
        repeat (20) tick();

        // Reset mid-XFER with load_req held high.
        mount(1'b0);
        snap();
        slot     = 2'd1;
        load_req = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (n_log - n0 >= 2 && sd.sd_ack && !sd.sd_rd) begin
                ok = 1'b1;
                break;
            end
        end
        check("rst_reach_xfer", 32'(ok), 32'd1);
        #2 RESET_n = 1'b0;
        #1;
        check("rst_async_flags",
              32'({sd.sd_rd, sd.sd_wr, bk_ena, bk_loading, bk_busy, bk_done, bk_err}), 32'd0);
        check("rst_async_lba", sd.sd_lba, 32'd0);
        repeat (2) tick();
        RESET_n = 1'b1;
        snap();
        repeat (30) tick();
        check("rst_no_restart", 32'({1'(n_log - n0), bk_busy}), 32'd0);
        load_req = 1'b0;
        tick();
        mount(1'b0);
        snap();
        load_req = 1'b1;
        repeat (2) tick();
        check("rst_new_edge", 32'({sd.sd_rd, sd.sd_lba[7:0]}), 32'h140);
        load_req = 1'b0;
        wait_idle(3000, ok);
        check("rst_new_done", 32'({ok, 1'(done_cnt - d0)}), 32'b11);
        check("global_viol", 32'(viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bk_sequencer.md
# bk_sequencer

Save-state sector sequencer for the SMS core. Converts the OSD "Load state"/"Save state" commands into a burst of consecutive 512-byte SD sector transfers for the selected save slot, driving `sd_lba`/`sd_rd`/`sd_wr` against the `hps_io` `sd_ack` handshake. It also tracks whether a writable save image is mounted (`bk_ena`), and holds the system in reset during loads (`bk_loading`). It sits beside `hps_io`, replacing the inline save/load logic of the top level, and adds transfer timeout and abort reporting.

## Interface
Parameters:
- `SECTORS`, 64: sectors per slot; power of two, 2..256; `LB = $clog2(SECTORS)`.
- `SLOT_BITS`, 2: slot-select width.
- `TIMEOUT`, 24'd5_000_000: maximum `clk_sys` cycles from request to `sd_ack` rise.

Ports:
- `clk_sys`  in  1  system clock.
- `RESET_n`  in  1  asynchronous, active-low reset.
- `downloading`  in  1  ROM download in progress (`ioctl_download`).
- `img_mounted`  in  1  image-mount strobe from `hps_io`.
- `img_readonly`  in  1  mounted image is read-only.
- `img_size_nz`  in  1  mounted image size is nonzero.
- `load_req`  in  1  level; load command from the OSD status bit.
- `save_req`  in  1  level; save command from the OSD status bit.
- `slot`  in  SLOT_BITS  save slot.
- `sd_ack`  in  1  sector transfer acknowledge from `hps_io`.
- `sd_lba`  out  32  sector address.
- `sd_rd`  out  1  sector read request.
- `sd_wr`  out  1  sector write request.
- `bk_ena`  out  1  writable save image present; gates the OSD entries.
- `bk_loading`  out  1  a load is in progress; OR'd into system reset.
- `bk_busy`  out  1  any transfer is in progress; drives `LED_USER`.
- `bk_done`  out  1  one-cycle pulse on successful completion.
- `bk_err`  out  1  one-cycle pulse on timeout or abort.

## Operation
- Reset values: all outputs 0; `sd_lba` 0; state IDLE.
- `bk_ena`:
  - Cleared on the rising edge of `downloading`.
  - Set when `downloading & img_mounted & img_size_nz & ~img_readonly`.
  - If both happen in the same cycle, set wins.
- Command detection:
  - Registered edge detect on `load_req & bk_ena` and on `save_req & bk_ena`.
  - Edges are ignored while not IDLE.
  - If both edges occur in the same cycle, load wins.
- States:
  - IDLE -> REQ on a command.
    - Latch `dir` (1 = load).
    - Set `sd_lba = {slot, LB'b0}`, zero-extended to 32 bits.
    - Set `sd_rd = dir`, `sd_wr = ~dir`, `bk_loading = dir`, `bk_busy = 1`.
  - REQ: wait for `sd_ack` to rise.
    - On the rise, clear `sd_rd`/`sd_wr` and go to XFER.
    - If the timeout counter reaches `TIMEOUT-1`, go to ERR.
  - XFER: wait for `sd_ack` to fall.
    - If `sd_lba[LB-1:0]` is all ones, or an abort is pending, go to FIN.
    - Otherwise increment only `sd_lba[LB-1:0]` (the slot bits never change), reassert the request, and go to REQ.
  - FIN: pulse `bk_done`, or `bk_err` if an abort was pending. Clear `bk_loading`/`bk_busy`, go to IDLE.
  - ERR: clear `sd_rd`/`sd_wr`/`bk_loading`/`bk_busy`, pulse `bk_err`, go to IDLE.
- Abort: a rising edge of `downloading` while not IDLE sets abort-pending. The current sector completes; no further sectors are requested.
- `slot` changes during a transfer have no effect; the slot is latched at start.
- The timeout counter is cleared on every entry to REQ. It does not run in XFER, because `hps_io` bounds the ack-high time.

## Timing
- Command edge at cycle N (input high at N, low at N-1): `sd_rd`/`sd_wr` is high at N+2 (one cycle edge register, one cycle state register).
- `sd_ack` rise at cycle M: `sd_rd`/`sd_wr` is low at M+2 (input edge register).
- `sd_ack` fall at cycle K: the next request is asserted at K+2.
- `bk_done` is asserted 2 cycles after the final `sd_ack` fall.
- `sd_lba` is stable throughout REQ and XFER.
- `bk_loading` rises in the same cycle as the first `sd_rd`.

## Structure
- Package `bk_pkg`:
  - state enum `bk_state_t` {IDLE, REQ, XFER, FIN, ERR};
  - `BK_DEFAULT_SECTORS = 64`;
  - `BK_DEFAULT_TIMEOUT`.
- Sub-module `bk_edge`: registered rising/falling edge detector with asynchronous active-low reset. It is instantiated for `load_req`, `save_req`, `downloading` and `sd_ack`.

## Test plan
- Save, slot 2, `SECTORS = 64`, `hps_io` model acks each request 5 cycles after it and holds ack 10 cycles -> 64 `sd_wr` pulses with `sd_lba` 0x80..0xBF in order, `sd_rd` never set, a single `bk_done`, `bk_loading` stays 0.
- Load, slot 0 -> `sd_rd` with `sd_lba` 0x00..0x3F; `bk_loading` high from the first request until the `bk_done` cycle.
- `bk_ena` = 0 (image read-only at mount) with a `load_req` edge -> no `sd_rd`/`sd_wr`, `bk_busy` stays 0.
- `TIMEOUT = 100`, model never acks -> `bk_err` pulse 100 cycles after the request, all outputs return to 0, and a new save command is accepted afterwards.
- `downloading` rises during sector 0x05 -> that sector completes, no sector 0x06 request, one `bk_err` pulse, `bk_ena` = 0.
- `RESET_n` asserted mid-XFER -> all outputs 0 asynchronously. After release with `load_req` held high, no transfer starts until a new rising edge.
